// File: rtl/tdm_demux8.sv
// Receive-side TDM demultiplexer: rebuilds 8-slot frames from a one-slot-per-clock stream.
// Optional build macro TDM_PARITY_EN adds a ninth even-parity slot and the PERR output.
module tdm_demux8 #(
  parameter int unsigned W = 1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           EN,
  input  logic           SYNC,
  input  logic [W-1:0]   Y,
  output logic [2:0]     S,
  output logic [8*W-1:0] D,
  output logic           VALID,
  output logic           ERR
`ifdef TDM_PARITY_EN
  ,
  output logic           PERR
`endif
);

`ifdef TDM_PARITY_EN
  localparam int unsigned CW   = 4;
  localparam int unsigned LAST = 8;
`else
  localparam int unsigned CW   = 3;
  localparam int unsigned LAST = 7;
`endif
  // Shadow holds every slot that precedes the final slot of the frame.
  localparam int unsigned SHN = LAST;

  typedef enum logic {
    HUNT,
    RUN
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SHN*W-1:0]     shadow_q, shadow_d;
  logic [8*W-1:0]       d_q, d_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
`ifdef TDM_PARITY_EN
  logic                 perr_q, perr_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    d_d      = d_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
`ifdef TDM_PARITY_EN
    perr_d   = 1'b0;
`endif
    if (!EN) begin
      unique case (state_q)
        HUNT: begin
          if (SYNC) begin
            shadow_d[W-1:0] = Y;
            cnt_d           = CW'(1);
            state_d         = RUN;
          end
        end
        RUN: begin
          if (SYNC) begin
            // A marker anywhere but slot 0 abandons the partial frame and resyncs.
            err_d           = (cnt_q != '0);
            shadow_d[W-1:0] = Y;
            cnt_d           = CW'(1);
          end else if (cnt_q == '0) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else if (cnt_q == CW'(LAST)) begin
            valid_d = 1'b1;
            cnt_d   = '0;
`ifdef TDM_PARITY_EN
            d_d    = shadow_q;
            perr_d = (^shadow_q) ^ Y[0];
`else
            d_d    = {Y, shadow_q};
`endif
          end else begin
            shadow_d[32'(cnt_q)*W +: W] = Y;
            cnt_d                       = cnt_q + CW'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= HUNT;
      cnt_q    <= '0;
      shadow_q <= '0;
      d_q      <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef TDM_PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      d_q      <= d_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
`ifdef TDM_PARITY_EN
      perr_q   <= perr_d;
`endif
    end
  end

  assign S     = cnt_q[2:0];
  assign D     = d_q;
  assign VALID = valid_q;
  assign ERR   = err_q;
`ifdef TDM_PARITY_EN
  assign PERR  = perr_q;
`endif

endmodule

// File: tb/tb_tdm_demux8.sv
// Scoreboard bench for tdm_demux8 (W=1); frames are queued when driven, popped on VALID.
module tb_tdm_demux8;
  localparam int unsigned W = 1;
`ifdef TDM_PARITY_EN
  localparam int unsigned LAST = 8;
`else
  localparam int unsigned LAST = 7;
`endif

  logic         CLK = 1'b0;
  logic         RST, EN, SYNC;
  logic [W-1:0] Y;
  logic [2:0]   S;
  logic [7:0]   D;
  logic         VALID, ERR;
`ifdef TDM_PARITY_EN
  logic         PERR;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned err_seen = 0;
  int unsigned exp_err  = 0;
  int unsigned cyc      = 0;
  logic [8:0]  sb[$];
  int unsigned valid_cyc[$];

  tdm_demux8 #(.W(W)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (EN),
    .SYNC (SYNC),
    .Y    (Y),
    .S    (S),
    .D    (D),
    .VALID(VALID),
    .ERR  (ERR)
`ifdef TDM_PARITY_EN
    ,
    .PERR (PERR)
`endif
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic en, input logic sync, input logic [W-1:0] y);
    EN = en; SYNC = sync; Y = y;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic slot_bit(input logic [7:0] v, input int unsigned k, input logic flip);
    if (k < 8) return v[k];
    return (^v) ^ flip;
  endfunction

  // Drives slots first..LAST; optional stall burst (with SYNC asserted, which must be ignored).
  task automatic send(input logic [7:0] v, input int unsigned first,
                      input int unsigned stall_at, input int unsigned stall_n, input logic flip);
    for (int unsigned k = first; k <= LAST; k++) begin
      if (k == LAST) sb.push_back({flip, v});
      tick(1'b0, k == 0, slot_bit(v, k, flip));
      if (k == stall_at) begin
        for (int unsigned i = 0; i < stall_n; i++) begin
          tick(1'b1, 1'b1, 1'b1);
          check_val("stall_s_hold", 64'(S), 64'(k + 1));
          check_val("stall_no_valid", 64'(VALID), 64'd0);
        end
      end
    end
  endtask

  task automatic partial(input logic [7:0] v, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) tick(1'b0, k == 0, v[k]);
  endtask

  always @(negedge CLK) begin
    logic [8:0] e;
    if (VALID || ERR) check_val("valid_err_excl", 64'(VALID & ERR), 64'd0);
    if (ERR) err_seen++;
    if (VALID) begin
      valid_cyc.push_back(cyc);
      check_val("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_val("sb_d", 64'(D), 64'(e[7:0]));
`ifdef TDM_PARITY_EN
        check_val("sb_perr", 64'(PERR), 64'(e[8]));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n0, c0;
    RST = 1'b1;
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    check_val("rst_s", 64'(S), 64'd0);
    check_val("rst_d", 64'(D), 64'd0);
    check_val("rst_valid", 64'(VALID), 64'd0);
    check_val("rst_err", 64'(ERR), 64'd0);
    RST = 1'b0;

    send(8'h4D, 0, 99, 0, 1'b0);
    check_val("clean_valid", 64'(VALID), 64'd1);
    check_val("clean_d", 64'(D), 64'h4D);
    check_val("clean_s_wrap", 64'(S), 64'd0);
    tick(1'b1, 1'b0, '0);
    check_val("clean_pulse_width", 64'(VALID), 64'd0);

    n0 = valid_cyc.size();
    send(8'hA5, 0, 99, 0, 1'b0);
    send(8'h3C, 0, 99, 0, 1'b0);
    tick(1'b1, 1'b0, '0);
    check_val("b2b_count", 64'(valid_cyc.size() - n0), 64'd2);
    if (valid_cyc.size() >= n0 + 2)
      check_val("b2b_spacing", 64'(valid_cyc[n0+1] - valid_cyc[n0]), 64'(LAST + 1));
    check_val("b2b_no_err", 64'(err_seen), 64'(exp_err));

    c0 = cyc;
    send(8'hF0, 0, 3, 3, 1'b0);
    check_val("stall_valid", 64'(VALID), 64'd1);
    tick(1'b1, 1'b0, '0);
    check_val("stall_latency", 64'(valid_cyc[$] - c0), 64'(LAST + 4));
    check_val("stall_d", 64'(D), 64'hF0);

    partial(8'hFF, 5);
    tick(1'b0, 1'b1, 1'b1);
    exp_err++;
    check_val("early_err", 64'(ERR), 64'd1);
    check_val("early_no_valid", 64'(VALID), 64'd0);
    check_val("early_d_hold", 64'(D), 64'hF0);
    check_val("early_resync_s", 64'(S), 64'd1);
    send(8'h81, 1, 99, 0, 1'b0);
    check_val("early_next_d", 64'(D), 64'h81);
    tick(1'b1, 1'b0, '0);

    tick(1'b0, 1'b0, 1'b1);
    exp_err++;
    check_val("miss_err", 64'(ERR), 64'd1);
    check_val("miss_s", 64'(S), 64'd0);
    tick(1'b0, 1'b0, 1'b1);
    check_val("hunt_quiet_err", 64'(ERR), 64'd0);
    check_val("hunt_s", 64'(S), 64'd0);
    send(8'h11, 0, 99, 0, 1'b0);
    check_val("hunt_next_d", 64'(D), 64'h11);
    tick(1'b1, 1'b0, '0);

`ifdef TDM_PARITY_EN
    send(8'h4D, 0, 99, 0, 1'b0);
    check_val("par_ok_perr", 64'(PERR), 64'd0);
    send(8'h4D, 0, 99, 0, 1'b1);
    check_val("par_bad_valid", 64'(VALID), 64'd1);
    check_val("par_bad_perr", 64'(PERR), 64'd1);
    tick(1'b1, 1'b0, '0);
`endif

    partial(8'h5A, 4);
    RST = 1'b1;
    tick(1'b0, 1'b0, 1'b1);
    check_val("midrst_s", 64'(S), 64'd0);
    check_val("midrst_d", 64'(D), 64'd0);
    check_val("midrst_valid", 64'(VALID), 64'd0);
    check_val("midrst_err", 64'(ERR), 64'd0);
    RST = 1'b0;
    tick(1'b0, 1'b0, 1'b1);
    check_val("midrst_hunt_s", 64'(S), 64'd0);
    send(8'hC3, 0, 99, 0, 1'b0);
    check_val("midrst_next_d", 64'(D), 64'hC3);

    for (int i = 0; i < 4; i++) send(8'($urandom_range(0, 255)), 0, 99, 0, 1'b0);
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    check_val("sb_drained", 64'(sb.size()), 64'd0);
    check_val("err_total", 64'(err_seen), 64'(exp_err));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
